// File: rtl/bitonic_pkg.sv
// Shared types and helpers for the time-multiplexed bitonic sort sequencer.
package bitonic_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SORT = 2'd1,
        OUT  = 2'd2
    } state_e;

    localparam logic DIR_ASC  = 1'b0;
    localparam logic DIR_DESC = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/bitonic_seq_ctrl_if.sv
// Producer/consumer streams of the bitonic sequencer; the master side drives words in and takes results out.
interface bitonic_seq_ctrl_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         dir;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         busy;

    modport master (
        output in_valid, in_data, dir, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, dir, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/cmp_exch.sv
// Single compare-exchange element: orders a pair for the low and high index positions.
module cmp_exch #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         asc,
    output logic [W-1:0] lo_pos,
    output logic [W-1:0] hi_pos
);
    logic swap;

    // Strict compares: equal words stay where they are.
    always_comb begin
        swap   = asc ? (a > b) : (a < b);
        lo_pos = swap ? b : a;
        hi_pos = swap ? a : b;
    end
endmodule

// File: rtl/bitonic_seq_ctrl.sv
// Loads a block of N words, walks every (k, j) stage of the bitonic network one pair
// per cycle through one compare-exchange element, then streams the sorted block out.
module bitonic_seq_ctrl
    import bitonic_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 32
) (
    input  logic                clk,
    input  logic                rst,
    bitonic_seq_ctrl_if.slave   bus
);
    localparam int LW = clog2(N);
    localparam int KW = LW + 1;
    localparam int PW = cnt_w(N / 2);
    localparam logic [PW-1:0] P_LAST = PW'(N / 2 - 1);

    state_e          state_q, state_d;
    logic [W-1:0]    mem_q [N];
    logic [W-1:0]    mem_d [N];
    logic [LW-1:0]   icnt_q, icnt_d, ocnt_q, ocnt_d;
    logic [KW-1:0]   k_q, k_d;
    logic [LW-1:0]   j_q, j_d;
    logic [PW-1:0]   p_q, p_d;
    logic            dir_q, dir_d;

    logic [LW-1:0]   p_ext, j_mask, idx_i, idx_l;
    logic            asc;
    logic [W-1:0]    cmp_lo, cmp_hi;

    // i is p with a zero spliced in at bit log2(j); j is always one-hot.
    always_comb begin
        p_ext  = LW'(p_q);
        j_mask = j_q - LW'(1);
        idx_i  = ((p_ext & ~j_mask) << 1) | (p_ext & j_mask);
        idx_l  = idx_i | j_q;
        asc    = ((KW'(idx_i) & k_q) == '0) ^ (dir_q == DIR_DESC);
    end

    cmp_exch #(.W(W)) u_cmp (
        .a      (mem_q[idx_i]),
        .b      (mem_q[idx_l]),
        .asc    (asc),
        .lo_pos (cmp_lo),
        .hi_pos (cmp_hi)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d       = state_q;
        mem_d         = mem_q;
        icnt_d        = icnt_q;
        ocnt_d        = ocnt_q;
        k_d           = k_q;
        j_d           = j_q;
        p_d           = p_q;
        dir_d         = dir_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.out_last  = 1'b0;
        bus.busy      = 1'b0;

        case (state_q)
            LOAD: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    mem_d[icnt_q] = bus.in_data;
                    icnt_d        = icnt_q + LW'(1);
                    if (icnt_q == '0) dir_d = bus.dir;
                    if (icnt_q == LW'(N - 1)) begin
                        icnt_d  = '0;
                        k_d     = KW'(2);
                        j_d     = LW'(1);
                        p_d     = '0;
                        state_d = SORT;
                    end
                end
            end

            SORT: begin
                bus.busy     = 1'b1;
                mem_d[idx_i] = cmp_lo;
                mem_d[idx_l] = cmp_hi;
                if (p_q == P_LAST) begin
                    p_d = '0;
                    if (j_q == LW'(1)) begin
                        if (k_q == KW'(N)) begin
                            state_d = OUT;
                            ocnt_d  = '0;
                        end else begin
                            k_d = k_q << 1;
                            j_d = k_q[LW-1:0];
                        end
                    end else begin
                        j_d = j_q >> 1;
                    end
                end else begin
                    p_d = p_q + PW'(1);
                end
            end

            OUT: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                bus.out_data  = mem_q[ocnt_q];
                bus.out_last  = (ocnt_q == LW'(N - 1));
                if (bus.out_ready) begin
                    ocnt_d = ocnt_q + LW'(1);
                    if (ocnt_q == LW'(N - 1)) begin
                        state_d = LOAD;
                        icnt_d  = '0;
                    end
                end
            end

            default: state_d = LOAD;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
            icnt_q  <= '0;
            ocnt_q  <= '0;
            k_q     <= '0;
            j_q     <= '0;
            p_q     <= '0;
            dir_q   <= 1'b0;
            // NOTE: the word array is cleared on reset so a discarded block never leaks out.
            for (int n = 0; n < N; n++) mem_q[n] <= '0;
        end else begin
            state_q <= state_d;
            icnt_q  <= icnt_d;
            ocnt_q  <= ocnt_d;
            k_q     <= k_d;
            j_q     <= j_d;
            p_q     <= p_d;
            dir_q   <= dir_d;
            for (int n = 0; n < N; n++) mem_q[n] <= mem_d[n];
        end
    end
endmodule

// File: tb/tb_bitonic_seq_ctrl.sv
// Scoreboard bench for bitonic_seq_ctrl: reference sort on load, in-order compare on unload.
module tb_bitonic_seq_ctrl;
    import bitonic_pkg::*;

    localparam int N  = 8;
    localparam int W  = 32;
    localparam int LW = 3;
    localparam int M  = (LW * (LW + 1) / 2) * (N / 2);

    typedef logic [W-1:0] blk_t [N];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bitonic_seq_ctrl_if #(.W(W)) bus ();

    bitonic_seq_ctrl #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int           n_checks = 0;
    int           n_fails  = 0;
    logic [W-1:0] exp_q [$];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic push_expected(input blk_t b, input logic d);
        logic [W-1:0] s [N];
        logic [W-1:0] t;
        s = b;
        for (int a = 1; a < N; a++) begin
            t = s[a];
            for (int c = a; c > 0; c--) begin
                if (s[c-1] > t) begin
                    s[c] = s[c-1];
                    s[c-1] = t;
                end
            end
        end
        for (int a = 0; a < N; a++) exp_q.push_back((d == DIR_DESC) ? s[N-1-a] : s[a]);
    endtask

    task automatic load_block(input blk_t b, input logic d, input bit gaps, input bit hold_after);
        int t;
        push_expected(b, d);
        for (int i = 0; i < N; i++) begin
            if (gaps) begin
                bus.in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            bus.in_valid = 1'b1;
            bus.in_data  = b[i];
            bus.dir      = (i == 0) ? d : ~d;
            t = 0;
            while (!bus.in_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (t == 100) begin
                check("in_ready_timeout", 0, 1);
                bus.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        bus.in_valid = hold_after;
        bus.in_data  = 32'hDEAD_BEEF;
    endtask

    task automatic recv_block(input int exp_lat, input int stall_idx, input int stall_len);
        int t;
        logic [W-1:0] want;
        bus.out_ready = 1'b1;
        for (int idx = 0; idx < N; idx++) begin
            t = 0;
            while (!bus.out_valid && t < 200) begin
                if (bus.in_valid) check("in_ready_sort", bus.in_ready, 0);
                @(negedge clk);
                t++;
            end
            if (t == 200) begin
                check("out_valid_timeout", 0, 1);
                bus.in_valid = 1'b0;
                return;
            end
            if (idx == 0 && exp_lat >= 0) check("latency", t, exp_lat);
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0_BAD0;
            check("out_data", bus.out_data, want);
            check("out_last", bus.out_last, logic'(idx == N - 1));
            if (idx == stall_idx) begin
                bus.out_ready = 1'b0;
                repeat (stall_len) begin
                    @(negedge clk);
                    check("stall_valid", bus.out_valid, 1);
                    check("stall_data", bus.out_data, want);
                end
                bus.out_ready = 1'b1;
            end
            if (bus.in_valid) check("in_ready_out", bus.in_ready, 0);
            if (idx == N - 1) bus.in_valid = 1'b0;
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        check("post_busy", bus.busy, 0);
        check("post_in_ready", bus.in_ready, 1);
        check("post_out_valid", bus.out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        blk_t blk_a, blk_dup, blk_r, blk_b;
        blk_a   = '{32'd7, 32'd3, 32'd9, 32'd1, 32'd8, 32'd2, 32'd6, 32'd5};
        blk_dup = '{32'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 32'd0, 32'd1, 32'hFFFF_FFFF};
        blk_r   = '{32'd4, 32'd3, 32'd2, 32'd1, 32'd8, 32'd7, 32'd6, 32'd5};
        blk_b   = '{32'd12, 32'd40, 32'd12, 32'd3, 32'd99, 32'd0, 32'd77, 32'd40};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.dir       = DIR_ASC;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_busy", bus.busy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_in_ready", bus.in_ready, 1);
        check("rel_busy", bus.busy, 0);

        load_block(blk_a, DIR_ASC, 1'b0, 1'b0);
        recv_block(M, -1, 0);

        load_block(blk_a, DIR_DESC, 1'b0, 1'b0);
        recv_block(M, -1, 0);

        load_block(blk_dup, DIR_ASC, 1'b0, 1'b0);
        recv_block(M, -1, 0);

        // Input gaps, input held high through SORT/OUT, output stall at word 3.
        load_block(blk_a, DIR_ASC, 1'b1, 1'b1);
        recv_block(M, 3, 5);

        // Reset in the middle of SORT discards the block.
        load_block(blk_a, DIR_DESC, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        check("pre_rst_busy", bus.busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_out_data", bus.out_data, 0);
        check("mid_rst_out_last", bus.out_last, 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rel_in_ready", bus.in_ready, 1);
        check("mid_rel_busy", bus.busy, 0);
        load_block(blk_r, DIR_ASC, 1'b0, 1'b0);
        recv_block(M, -1, 0);

        // Back-to-back blocks with opposite directions.
        load_block(blk_a, DIR_ASC, 1'b0, 1'b0);
        recv_block(M, -1, 0);
        load_block(blk_b, DIR_DESC, 1'b0, 1'b0);
        recv_block(M, 6, 2);

        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
